// File: rtl/char_buffer_writer_pkg.sv
// char_buffer_writer_pkg: shared text-buffer geometry, character codes and writer FSM states
package char_buffer_writer_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
    localparam int GAME_COLS_MAX = 16;
    localparam int GAME_ROWS_MAX = 16;
    localparam logic [6:0] LF_CHAR = 7'h0A;
    localparam logic [6:0] DEFAULT_FILL_CHAR = 7'h20;
    typedef enum logic {CLEAR, IDLE} wr_state_t;
endpackage

// File: rtl/char_buffer_writer_ram.sv
// char_ram: 256x7 character store, synchronous write, asynchronous read, address {x,y}
module char_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [6:0] wdata,
    input  logic [7:0] raddr,
    output logic [6:0] rdata
);
    logic [6:0] mem [256];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/char_buffer_writer.sv
// char_buffer_writer: cursor-driven text buffer writer with clear sequencer and zero-latency read port
module char_buffer_writer
    import char_buffer_writer_pkg::*;
#(
    parameter int         TEXT_SIZE_X = 16,
    parameter int         TEXT_SIZE_Y = 6,
    parameter logic [6:0] FILL_CHAR   = DEFAULT_FILL_CHAR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [6:0] wr_char,
    output logic       wr_ready,
    input  logic       cmd_clear,
    output logic       busy,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code
);
    localparam logic [3:0] X_LAST = 4'(TEXT_SIZE_X - 1);
    localparam logic [3:0] Y_LAST = 4'(TEXT_SIZE_Y - 1);
    localparam logic [4:0] X_SIZE = 5'(TEXT_SIZE_X);
    localparam logic [4:0] Y_SIZE = 5'(TEXT_SIZE_Y);
    wr_state_t  state, state_nx;
    logic [3:0] clr_x, clr_y, cur_x, cur_y, cur_y_nx;
    logic       clr_done, accept, we;
    logic [7:0] waddr;
    logic [6:0] wdata, rdata;
    assign busy     = state == CLEAR;
    assign wr_ready = state == IDLE && !cmd_clear;
    assign accept   = wr_valid && wr_ready;
    assign clr_done = clr_x == X_LAST && clr_y == Y_LAST;
    assign cur_y_nx = cur_y == Y_LAST ? 4'd0 : cur_y + 4'd1;
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == CLEAR) state_nx = clr_done ? IDLE : CLEAR;
        else if (cmd_clear) state_nx = CLEAR;
    end
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            clr_x <= '0;
            clr_y <= '0;
        end else if (clr_x == X_LAST) begin
            clr_x <= '0;
            clr_y <= clr_y + 4'd1;
        end else begin
            clr_x <= clr_x + 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (accept) begin
            if (wr_char == LF_CHAR || cur_x == X_LAST) begin
                cur_x <= '0;
                cur_y <= cur_y_nx;
            end else begin
                cur_x <= cur_x + 4'd1;
            end
        end
    end
    always_comb begin
        we    = busy || (accept && wr_char != LF_CHAR);
        waddr = busy ? {clr_x, clr_y} : {cur_x, cur_y};
        wdata = busy ? FILL_CHAR : wr_char;
    end
    char_ram u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(char_xy),
        .rdata(rdata)
    );
    assign char_code = (!busy && {1'b0, char_xy[7:4]} < X_SIZE && {1'b0, char_xy[3:0]} < Y_SIZE)
                       ? rdata : 7'h00;
endmodule
